// File: rtl/tower_grid_pkg.sv
// Shared definitions for the tower-grid occupancy memory: request/status
// encodings and default grid dimensions used by the writer and the placer datapath.
package tower_grid_pkg;

    localparam int GRID_COLS_DEF = 8;
    localparam int GRID_ROWS_DEF = 8;

    typedef enum logic [1:0] {
        OP_PLACE  = 2'b00,
        OP_REMOVE = 2'b01,
        OP_CLEAR  = 2'b10,
        OP_RSVD   = 2'b11
    } grid_op_e;

    typedef enum logic [1:0] {
        ST_OK       = 2'b00,
        ST_CONFLICT = 2'b01,
        ST_RANGE    = 2'b10,
        ST_ILLEGAL  = 2'b11
    } grid_status_e;

endpackage

// File: rtl/grid_occupancy_writer_if.sv
// Request/response handshake between the game controller (master) and the
// occupancy writer (slave). Coordinate widths may exceed the grid to allow range checks.
interface grid_occupancy_writer_if #(
    parameter int X_W = 3,
    parameter int Y_W = 3
);
    logic           req_valid;
    logic           req_ready;
    logic [1:0]     req_op;
    logic [X_W-1:0] req_x;
    logic [Y_W-1:0] req_y;
    logic           rsp_valid;
    logic [1:0]     rsp_status;

    modport master (
        output req_valid, req_op, req_x, req_y,
        input  req_ready, rsp_valid, rsp_status
    );

    modport slave (
        input  req_valid, req_op, req_x, req_y,
        output req_ready, rsp_valid, rsp_status
    );
endinterface

// File: rtl/tower_row_update.sv
// Combinational row edit: flags a place on an occupied cell or a remove on an
// empty cell, and produces the updated row word.
module tower_row_update
    import tower_grid_pkg::*;
#(
    parameter int GRID_COLS = GRID_COLS_DEF,
    parameter int X_W       = $clog2(GRID_COLS)
) (
    input  logic [GRID_COLS-1:0] row,
    input  logic [X_W-1:0]       x,
    input  logic [1:0]           op,
    output logic                 conflict,
    output logic [GRID_COLS-1:0] new_row
);

    logic [GRID_COLS-1:0] mask;
    logic                 hit;

    always_comb begin
        mask     = GRID_COLS'(1) << x;
        hit      = |(row & mask);
        conflict = 1'b0;
        new_row  = row;
        case (op)
            OP_PLACE: begin
                conflict = hit;
                new_row  = row | mask;
            end
            OP_REMOVE: begin
                conflict = ~hit;
                new_row  = row & ~mask;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/grid_occupancy_writer.sv
// Read-modify-write front end of the row-per-word occupancy memory with a running
// tower count. Define GRID_CLEAR_EN to build the full-grid clear sweep for op 10.
module grid_occupancy_writer
    import tower_grid_pkg::*;
#(
    parameter int GRID_COLS = GRID_COLS_DEF,
    parameter int GRID_ROWS = GRID_ROWS_DEF,
    parameter int X_W       = $clog2(GRID_COLS),
    parameter int Y_W       = $clog2(GRID_ROWS)
) (
    input  logic                                   clk,
    input  logic                                   reset,
    grid_occupancy_writer_if.slave                 req_if,
    output logic [$clog2(GRID_ROWS)-1:0]           mem_addr,
    input  logic [GRID_COLS-1:0]                   mem_rdata,
    output logic [GRID_COLS-1:0]                   mem_wdata,
    output logic                                   mem_we,
    output logic [$clog2(GRID_ROWS*GRID_COLS+1)-1:0] tower_count
);

    localparam int AW = $clog2(GRID_ROWS);
    localparam int CW = $clog2(GRID_ROWS*GRID_COLS+1);

    localparam logic [CW-1:0] CNT_MAX  = CW'(GRID_ROWS*GRID_COLS);
    localparam logic [X_W:0]  COLS_LIM = (X_W+1)'(GRID_COLS);
    localparam logic [Y_W:0]  ROWS_LIM = (Y_W+1)'(GRID_ROWS);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_READ    = 3'd1;
    localparam logic [2:0] S_RD_WAIT = 3'd2;
    localparam logic [2:0] S_CHECK   = 3'd3;
    localparam logic [2:0] S_WRITE   = 3'd4;
    localparam logic [2:0] S_DONE    = 3'd6;
`ifdef GRID_CLEAR_EN
    localparam logic [2:0] S_CLEAR   = 3'd5;
    localparam logic [AW-1:0] LAST_ROW = AW'(GRID_ROWS-1);
`endif

    logic [2:0]           state;
    logic [1:0]           op_q;
    logic [X_W-1:0]       x_q;
    logic [Y_W-1:0]       y_q;
    logic [GRID_COLS-1:0] row_q;
    logic [1:0]           rsp_status_q;
    logic                 row_conflict;
    logic [GRID_COLS-1:0] row_next;
    logic                 op_illegal;
    logic                 out_of_range;

    assign req_if.req_ready  = (state == S_IDLE);
    assign req_if.rsp_valid  = (state == S_DONE);
    assign req_if.rsp_status = rsp_status_q;

    always_comb begin
        op_illegal = (req_if.req_op == OP_RSVD);
`ifndef GRID_CLEAR_EN
        op_illegal = op_illegal || (req_if.req_op == OP_CLEAR);
`endif
        out_of_range = ({1'b0, req_if.req_x} >= COLS_LIM) ||
                       ({1'b0, req_if.req_y} >= ROWS_LIM);
    end

    tower_row_update #(
        .GRID_COLS (GRID_COLS),
        .X_W       (X_W)
    ) u_row_update (
        .row      (row_q),
        .x        (x_q),
        .op       (op_q),
        .conflict (row_conflict),
        .new_row  (row_next)
    );

`ifdef GRID_CLEAR_EN
    logic [AW-1:0] clr_row;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            clr_row <= '0;
        else if (state != S_CLEAR)
            clr_row <= '0;
        else
            clr_row <= clr_row + AW'(1);
    end
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= S_IDLE;
            op_q         <= '0;
            x_q          <= '0;
            y_q          <= '0;
            row_q        <= '0;
            rsp_status_q <= ST_OK;
            tower_count  <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (req_if.req_valid) begin
                        op_q <= req_if.req_op;
                        x_q  <= req_if.req_x;
                        y_q  <= req_if.req_y;
                        if (op_illegal) begin
                            rsp_status_q <= ST_ILLEGAL;
                            state        <= S_DONE;
                        end else if (out_of_range) begin
                            rsp_status_q <= ST_RANGE;
                            state        <= S_DONE;
`ifdef GRID_CLEAR_EN
                        end else if (req_if.req_op == OP_CLEAR) begin
                            state <= S_CLEAR;
`endif
                        end else begin
                            state <= S_READ;
                        end
                    end
                end
                S_READ: state <= S_RD_WAIT;
                S_RD_WAIT: begin
                    row_q <= mem_rdata;
                    state <= S_CHECK;
                end
                S_CHECK: begin
                    if (row_conflict) begin
                        rsp_status_q <= ST_CONFLICT;
                        state        <= S_DONE;
                    end else begin
                        state <= S_WRITE;
                    end
                end
                S_WRITE: begin
                    // saturate rather than wrap if memory and count ever disagree
                    if (op_q == OP_PLACE) begin
                        if (tower_count != CNT_MAX)
                            tower_count <= tower_count + CW'(1);
                    end else if (tower_count != '0) begin
                        tower_count <= tower_count - CW'(1);
                    end
                    rsp_status_q <= ST_OK;
                    state        <= S_DONE;
                end
`ifdef GRID_CLEAR_EN
                S_CLEAR: begin
                    if (clr_row == LAST_ROW) begin
                        tower_count  <= '0;
                        rsp_status_q <= ST_OK;
                        state        <= S_DONE;
                    end
                end
`endif
                S_DONE:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

    // memory port is decoded from state so an async reset drops mem_we at once
    always_comb begin
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        case (state)
            S_READ: mem_addr = y_q[AW-1:0];
            S_WRITE: begin
                mem_we    = 1'b1;
                mem_addr  = y_q[AW-1:0];
                mem_wdata = row_next;
            end
`ifdef GRID_CLEAR_EN
            S_CLEAR: begin
                mem_we   = 1'b1;
                mem_addr = clr_row;
            end
`endif
            default: ;
        endcase
    end

endmodule

// File: tb/tb_grid_occupancy_writer.sv
// Bench for grid_occupancy_writer: synchronous row memory model, behavioural grid
// model, and scoreboards for expected writes and responses.
`timescale 1ns/1ps
module tb_grid_occupancy_writer;
    import tower_grid_pkg::*;

    localparam int COLS = 8;
    localparam int ROWS = 8;
    localparam int XW   = 4;
    localparam int YW   = 4;
    localparam int AW   = 3;
    localparam int CW   = 7;

    logic            clk = 1'b0;
    logic            reset = 1'b1;
    logic [AW-1:0]   mem_addr;
    logic [COLS-1:0] mem_rdata = '0;
    logic [COLS-1:0] mem_wdata;
    logic            mem_we;
    logic [CW-1:0]   tower_count;

    grid_occupancy_writer_if #(.X_W(XW), .Y_W(YW)) bus ();

    grid_occupancy_writer #(
        .GRID_COLS (COLS),
        .GRID_ROWS (ROWS),
        .X_W       (XW),
        .Y_W       (YW)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .req_if      (bus),
        .mem_addr    (mem_addr),
        .mem_rdata   (mem_rdata),
        .mem_wdata   (mem_wdata),
        .mem_we      (mem_we),
        .tower_count (tower_count)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [COLS-1:0] ram [ROWS];
    always @(posedge clk) begin
        if (mem_we) ram[mem_addr] <= mem_wdata;
        mem_rdata <= ram[mem_addr];
    end

    typedef struct {
        logic [1:0] st;
        int         lat;
        int         acc;
        int         cnt;
    } rsp_exp_t;

    typedef struct {
        logic [AW-1:0]   addr;
        logic [COLS-1:0] data;
        int              lat;
        int              acc;
    } wr_exp_t;

    rsp_exp_t rsp_q[$];
    wr_exp_t  wr_q[$];
    rsp_exp_t mon_r;
    wr_exp_t  mon_w;

    logic [COLS-1:0] grid_m [ROWS];
    int count_m = 0;
    int n_vec = 0;
    int n_err = 0;

    always @(negedge clk) begin
        if (!reset && mem_we) begin
            n_vec++;
            if (wr_q.size() == 0) begin
                n_err++;
                $display("FAIL unexpected_write: addr %0d data %h at cycle %0d, required no write",
                         mem_addr, mem_wdata, cyc);
            end else begin
                mon_w = wr_q.pop_front();
                if (mem_addr !== mon_w.addr || mem_wdata !== mon_w.data ||
                    (cyc - mon_w.acc + 1) != mon_w.lat) begin
                    n_err++;
                    $display("FAIL write: addr %0d data %h cycle %0d, required addr %0d data %h cycle %0d",
                             mem_addr, mem_wdata, cyc - mon_w.acc + 1, mon_w.addr, mon_w.data, mon_w.lat);
                end
            end
        end
        if (!reset && bus.rsp_valid) begin
            n_vec++;
            if (rsp_q.size() == 0) begin
                n_err++;
                $display("FAIL unexpected_rsp: status %0d at cycle %0d, required no response",
                         bus.rsp_status, cyc);
            end else begin
                mon_r = rsp_q.pop_front();
                if (bus.rsp_status !== mon_r.st || (cyc - mon_r.acc + 1) != mon_r.lat ||
                    int'(tower_count) != mon_r.cnt) begin
                    n_err++;
                    $display("FAIL rsp: status %0d cycle %0d count %0d, required status %0d cycle %0d count %0d",
                             bus.rsp_status, cyc - mon_r.acc + 1, tower_count, mon_r.st, mon_r.lat, mon_r.cnt);
                end
            end
        end
    end

    task automatic issue(input logic [1:0] op, input logic [XW-1:0] x,
                         input logic [YW-1:0] y, output int acc);
        int waited = 0;
        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.req_op    = op;
        bus.req_x     = x;
        bus.req_y     = y;
        while (bus.req_ready !== 1'b1 && waited < 40) begin
            @(negedge clk);
            waited++;
        end
        if (bus.req_ready !== 1'b1) begin
            n_vec++;
            n_err++;
            $display("FAIL accept_timeout: req_ready %b after %0d cycles, required 1", bus.req_ready, waited);
            bus.req_valid = 1'b0;
            acc = -100;
        end else begin
            @(posedge clk);
            #1;
            acc = cyc;
            bus.req_valid = 1'b0;
        end
    endtask

    // issue one request and queue what the grid model says must happen
    task automatic do_req(input logic [1:0] op, input logic [XW-1:0] x,
                          input logic [YW-1:0] y, output int acc);
        rsp_exp_t        r;
        wr_exp_t         w;
        logic [COLS-1:0] row;
        int xi, yi;
        xi = int'(x);
        yi = int'(y);
        issue(op, x, y, acc);
        if (op == OP_RSVD) begin
            r = '{ST_ILLEGAL, 1, acc, count_m};
        end else if (xi >= COLS || yi >= ROWS) begin
            r = '{ST_RANGE, 1, acc, count_m};
        end else if (op == OP_CLEAR) begin
`ifdef GRID_CLEAR_EN
            for (int i = 0; i < ROWS; i++) begin
                w = '{AW'(i), '0, i + 1, acc};
                wr_q.push_back(w);
                grid_m[i] = '0;
            end
            count_m = 0;
            r = '{ST_OK, ROWS + 1, acc, 0};
`else
            r = '{ST_ILLEGAL, 1, acc, count_m};
`endif
        end else begin
            row = grid_m[yi];
            if ((op == OP_PLACE) == (row[xi] == 1'b1)) begin
                r = '{ST_CONFLICT, 4, acc, count_m};
            end else begin
                row[xi]    = (op == OP_PLACE);
                grid_m[yi] = row;
                count_m    = (op == OP_PLACE) ? count_m + 1 : count_m - 1;
                w = '{AW'(yi), row, 4, acc};
                wr_q.push_back(w);
                r = '{ST_OK, 5, acc, count_m};
            end
        end
        rsp_q.push_back(r);
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((rsp_q.size() != 0 || wr_q.size() != 0) && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (rsp_q.size() != 0 || wr_q.size() != 0) begin
            n_vec++;
            n_err++;
            $display("FAIL idle_timeout: %0d responses %0d writes pending, required 0 0",
                     rsp_q.size(), wr_q.size());
            rsp_q.delete();
            wr_q.delete();
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        #2;
        n_vec++;
        if (bus.req_ready !== 1'b1 || bus.rsp_valid !== 1'b0 || bus.rsp_status !== 2'b00) begin
            n_err++;
            $display("FAIL reset_handshake: ready %b rsp_valid %b status %b, required 1 0 00",
                     bus.req_ready, bus.rsp_valid, bus.rsp_status);
        end
        n_vec++;
        if (mem_we !== 1'b0 || mem_addr !== '0 || mem_wdata !== '0 || tower_count !== '0) begin
            n_err++;
            $display("FAIL reset_mem: we %b addr %0d wdata %h count %0d, required 0 0 00 0",
                     mem_we, mem_addr, mem_wdata, tower_count);
        end
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_place();
        int acc;
        do_req(OP_PLACE, 4'd3, 4'd2, acc);
        n_vec++;
        if (bus.req_ready !== 1'b0) begin
            n_err++;
            $display("FAIL busy_ready: req_ready %b in cycle 1, required 0", bus.req_ready);
        end
        wait_idle();
        n_vec++;
        if (tower_count !== CW'(1) || bus.rsp_status !== ST_OK) begin
            n_err++;
            $display("FAIL place_hold: count %0d status %0d, required 1 0", tower_count, bus.rsp_status);
        end
    endtask

    task automatic test_conflict();
        int acc;
        do_req(OP_PLACE, 4'd3, 4'd2, acc);
        wait_idle();
        do_req(OP_REMOVE, 4'd3, 4'd2, acc);
        wait_idle();
        do_req(OP_REMOVE, 4'd3, 4'd2, acc);
        wait_idle();
        n_vec++;
        if (tower_count !== CW'(0) || bus.rsp_status !== ST_CONFLICT) begin
            n_err++;
            $display("FAIL conflict_hold: count %0d status %0d, required 0 1", tower_count, bus.rsp_status);
        end
    endtask

    task automatic test_range_illegal();
        int acc;
        do_req(OP_PLACE, 4'd9, 4'd2, acc);
        wait_idle();
        do_req(OP_REMOVE, 4'd1, 4'd8, acc);
        wait_idle();
        do_req(OP_RSVD, 4'd1, 4'd1, acc);
        wait_idle();
        do_req(OP_RSVD, 4'd9, 4'd9, acc);
        wait_idle();
        n_vec++;
        if (bus.rsp_status !== ST_ILLEGAL) begin
            n_err++;
            $display("FAIL illegal_hold: status %0d, required 3", bus.rsp_status);
        end
    endtask

    task automatic test_clear();
        int acc;
        do_req(OP_PLACE, 4'd0, 4'd0, acc);
        wait_idle();
        do_req(OP_PLACE, 4'd7, 4'd7, acc);
        wait_idle();
        do_req(OP_PLACE, 4'd5, 4'd4, acc);
        wait_idle();
        do_req(OP_CLEAR, 4'd0, 4'd0, acc);
        wait_idle();
        n_vec++;
        if (int'(tower_count) != count_m) begin
            n_err++;
            $display("FAIL clear_count: count %0d, required %0d", tower_count, count_m);
        end
    endtask

    task automatic test_back_to_back();
        int acc_a, acc_b;
        do_req(OP_PLACE, 4'd2, 4'd6, acc_a);
        do_req(OP_REMOVE, 4'd2, 4'd6, acc_b);
        n_vec++;
        if (acc_b - acc_a != 6) begin
            n_err++;
            $display("FAIL back_to_back: second accept %0d cycles after first, required 6", acc_b - acc_a);
        end
        do_req(OP_PLACE, 4'd6, 4'd1, acc_a);
        wait_idle();
    endtask

    task automatic test_reset_mid_write();
        int acc, n;
        do_req(OP_PLACE, 4'd1, 4'd1, acc);
        n = 0;
        while (mem_we !== 1'b1 && n < 10) begin
            @(negedge clk);
            n++;
        end
        n_vec++;
        if (mem_we !== 1'b1) begin
            n_err++;
            $display("FAIL write_seen: mem_we %b after %0d cycles, required 1", mem_we, n);
        end
        #2;
        reset = 1'b1;
        #1;
        n_vec++;
        if (mem_we !== 1'b0 || bus.req_ready !== 1'b1 || bus.rsp_valid !== 1'b0 || tower_count !== '0) begin
            n_err++;
            $display("FAIL reset_mid_write: we %b ready %b rsp_valid %b count %0d, required 0 1 0 0",
                     mem_we, bus.req_ready, bus.rsp_valid, tower_count);
        end
        rsp_q.delete();
        grid_m[1][1] = 1'b0;
        count_m = 0;
        @(negedge clk);
        reset = 1'b0;
        repeat (6) @(negedge clk);
        do_req(OP_PLACE, 4'd1, 4'd1, acc);
        wait_idle();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t, required finish", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        bus.req_valid = 1'b0;
        bus.req_op    = '0;
        bus.req_x     = '0;
        bus.req_y     = '0;
        for (int i = 0; i < ROWS; i++) begin
            ram[i]    = '0;
            grid_m[i] = '0;
        end
        test_reset();
        test_place();
        test_conflict();
        test_range_illegal();
        test_clear();
        test_back_to_back();
        test_reset_mid_write();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/grid_occupancy_writer.md
# grid_occupancy_writer

Writer side of the tower-grid occupancy memory: accepts place/remove/clear requests from the game controller and performs read-modify-write cycles on the row-per-word grid memory that the tower placer scans. Each memory word holds one grid row, one bit per column (1 = occupied). The block rejects conflicting or out-of-range requests and maintains a running tower count.

## Interface
- GRID_COLS, 8, columns per row; equals the memory word width.
- GRID_ROWS, 8, rows in the grid; equals the memory depth.
- clk  in  1  system clock; all logic on rising edge.
- reset  in  1  one clock; reset is asynchronous and active-high.
- req_valid  in  1  request present; fields held stable until accepted.
- req_ready  out  1  high exactly when FSM is in IDLE.
- req_op  in  2  00 place, 01 remove, 10 clear, 11 reserved.
- req_x  in  $clog2(GRID_COLS)  column index.
- req_y  in  $clog2(GRID_ROWS)  row index.
- rsp_valid  out  1  one-cycle pulse when a request completes.
- rsp_status  out  2  00 OK, 01 CONFLICT, 10 RANGE, 11 ILLEGAL; valid with rsp_valid, held until next completion.
- mem_addr  out  $clog2(GRID_ROWS)  memory row address.
- mem_rdata  in  GRID_COLS  row read data; 1-cycle synchronous read latency.
- mem_wdata  out  GRID_COLS  row write data.
- mem_we  out  1  write enable, one cycle per write.
- tower_count  out  $clog2(GRID_ROWS*GRID_COLS+1)  number of occupied cells.

## Operation
- States: IDLE, READ, RD_WAIT, CHECK, WRITE, CLEAR, DONE.
- IDLE: on req_valid && req_ready, latch op/x/y. ILLEGAL if op=11 (or op=10 with clear compiled out); RANGE if x≥GRID_COLS or y≥GRID_ROWS; either goes straight to DONE. Op 10 goes to CLEAR with row counter 0. Otherwise go to READ.
- READ: mem_addr = y. RD_WAIT: capture mem_rdata into row register.
- CHECK: place on a set bit or remove on a clear bit gives CONFLICT, then DONE. Otherwise go to WRITE.
- WRITE: mem_we=1, mem_addr=y, mem_wdata = row | (1<<x) for place, or row & ~(1<<x) for remove. tower_count ±1; it never wraps. Then DONE with OK.
- CLEAR: mem_we=1, mem_wdata=0, mem_addr=counter; counter runs 0..GRID_ROWS-1, one row per cycle. After the last row, tower_count=0 and go to DONE with OK.
- DONE: rsp_valid=1 for one cycle, update rsp_status, return to IDLE.
- Reset mid-operation: the request is abandoned with no response, FSM returns to IDLE, mem_we drops immediately. A partially cleared grid is permitted.

## Timing
- Reset values: req_ready=1 (IDLE), rsp_valid=0, rsp_status=00, mem_we=0, mem_addr=0, mem_wdata=0, tower_count=0.
- Accept edge = cycle 0. RANGE/ILLEGAL: rsp_valid in cycle 1. CONFLICT: cycle 4. OK place/remove: write in cycle 4, rsp_valid in cycle 5. Clear: writes in cycles 1..GRID_ROWS, rsp_valid in cycle GRID_ROWS+1.
- req_ready is combinational from state and is low from cycle 1 until back in IDLE. A request asserted while busy waits and is not dropped.
- Back-to-back requests: the next accept is possible in the cycle after rsp_valid.

## Configuration
- GRID_CLEAR_EN defined: op 10 performs the full-grid clear sweep described above.
- GRID_CLEAR_EN undefined: the CLEAR state and row counter are not built. Op 10 returns ILLEGAL in cycle 1 with no memory write.

## Structure
- Shared package tower_grid_pkg holds: op encodings (OP_PLACE, OP_REMOVE, OP_CLEAR), status encodings (ST_OK, ST_CONFLICT, ST_RANGE, ST_ILLEGAL), and default grid dimensions shared with the placer datapath.
- One sub-module, tower_row_update: combinational; takes row, x and op, and produces the conflict flag and the new row.

## Test plan
- Reset, then place (x=3, y=2) on an empty grid → mem_we in cycle 4 with addr 2, wdata 8'h08; rsp OK in cycle 5; tower_count=1.
- Place (3,2) again → no mem_we; rsp CONFLICT in cycle 4; tower_count stays 1.
- Remove (3,2) → wdata 8'h00, OK, tower_count=0. Repeat the remove → CONFLICT.
- req_x=9 with GRID_COLS=8 (widened bench), or op=11 → RANGE / ILLEGAL in cycle 1; no memory access.
- With GRID_CLEAR_EN, place 3 towers then clear → 8 consecutive writes of 0 to addr 0..7, rsp OK in cycle 9, tower_count=0. Without the macro → ILLEGAL in cycle 1.
- Assert reset during WRITE of a place → mem_we falls immediately, no rsp_valid, req_ready=1, tower_count=0.
